// File: rtl/piezo_pkg.sv
// Shared types and pitch constants for the piezo tone generator.
// Half periods are derived from the clock frequency at elaboration time.
package piezo_pkg;

  localparam int IDX_W   = 5;
  localparam int NUM_DEG = 7;

  localparam int F_C = 262;
  localparam int F_D = 294;
  localparam int F_E = 330;
  localparam int F_F = 349;
  localparam int F_G = 392;
  localparam int F_A = 440;
  localparam int F_B = 494;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic int freq_of(input int degree);
    int f;
    case (degree)
      0:       f = F_C;
      1:       f = F_D;
      2:       f = F_E;
      3:       f = F_F;
      4:       f = F_G;
      5:       f = F_A;
      default: f = F_B;
    endcase
    return f;
  endfunction

  function automatic int hp_of(input int clk_hz, input int degree);
    return clk_hz / (2 * freq_of(degree));
  endfunction

endpackage

// File: rtl/piezo_key_select.sv
// Synchronises key levels, detects presses and picks the sounding key (latest press, lowest index on ties).
// Outputs are registered 3 cycles after the first sampled key edge; no backpressure.
module piezo_key_select
  import piezo_pkg::*;
#(
  parameter int NUM_KEYS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                any_held,
  output logic                new_note_valid,
  output logic [IDX_W-1:0]    sel_idx
);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_prev;
  logic                r_any;
  logic                r_new;
  logic [IDX_W-1:0]    r_sel;

  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_cur_mask;
  logic                w_cur_held;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_cur_mask = NUM_KEYS'(1) << r_sel;
  assign w_cur_held = |(w_cur_mask & r_sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_any   <= 1'b0;
      r_new   <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_any   <= |r_sync2;
      // A fresh press always wins; otherwise fall back only when the current key was let go.
      if (|w_rise) begin
        r_sel <= lowest(w_rise);
        r_new <= 1'b1;
      end else if (!w_cur_held && (|r_sync2)) begin
        r_sel <= lowest(r_sync2);
        r_new <= 1'b1;
      end else begin
        r_new <= 1'b0;
      end
    end
  end

  assign any_held       = r_any;
  assign new_note_valid = r_new;
  assign sel_idx        = r_sel;

endmodule

// File: rtl/piezo_tone_gen.sv
// Square-wave piezo driver for the most recently pressed key, with octave shift and release hold.
// piezo rises 4 cycles after a key press is first sampled; no backpressure.
module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int NUM_KEYS    = 8,
  parameter int CLK_HZ      = 20_000_000,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 2_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          oct_shift,
  output logic                piezo,
  output logic                active,
  output logic [IDX_W-1:0]    note_idx
);

  localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;

  localparam logic [CNT_W-1:0] HP_TAB [NUM_DEG] = '{
    CNT_W'(hp_of(CLK_HZ, 0)), CNT_W'(hp_of(CLK_HZ, 1)), CNT_W'(hp_of(CLK_HZ, 2)),
    CNT_W'(hp_of(CLK_HZ, 3)), CNT_W'(hp_of(CLK_HZ, 4)), CNT_W'(hp_of(CLK_HZ, 5)),
    CNT_W'(hp_of(CLK_HZ, 6))
  };

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_note;
  logic [CNT_W-1:0] r_hp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_piezo;
  logic [31:0]      r_hold;

  logic             w_any_held;
  logic             w_new_vld;
  logic [IDX_W-1:0] w_sel_idx;
  logic [CNT_W-1:0] w_hp_new;
  logic [CNT_W-1:0] w_hp_cur;
  logic             w_toggle;

  function automatic logic [CNT_W-1:0] note_hp(input logic [IDX_W-1:0] idx,
                                               input logic [1:0]       oct);
    logic [2:0]       deg;
    logic [IDX_W-1:0] sh;
    logic [CNT_W-1:0] hp;
    deg = 3'(idx % IDX_W'(NUM_DEG));
    sh  = idx / IDX_W'(NUM_DEG) + IDX_W'(oct);
    hp  = HP_TAB[deg] >> sh;
    return (hp == '0) ? CNT_W'(1) : hp;
  endfunction

  piezo_key_select #(
    .NUM_KEYS(NUM_KEYS)
  ) u_key_select (
    .clk           (clk),
    .reset         (reset),
    .keys          (keys),
    .any_held      (w_any_held),
    .new_note_valid(w_new_vld),
    .sel_idx       (w_sel_idx)
  );

  assign w_hp_new = note_hp(w_sel_idx, oct_shift);
  assign w_hp_cur = note_hp(r_note, oct_shift);
  assign w_toggle = (r_cnt == r_hp - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_held) w_next = PLAY;
      PLAY:    if (!w_any_held) w_next = (HOLD_CYCLES == 0) ? IDLE : RELEASE;
      RELEASE: begin
        if (w_new_vld)                w_next = PLAY;
        else if (r_hold == HOLD_LAST) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    piezo    = r_piezo;
    active   = (r_state != IDLE);
    note_idx = (r_state == IDLE) ? '0 : r_note;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_note  <= '0;
      r_hp    <= '0;
      r_cnt   <= '0;
      r_piezo <= 1'b0;
      r_hold  <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt   <= '0;
        r_piezo <= w_any_held;
        if (w_any_held) begin
          r_note <= w_sel_idx;
          r_hp   <= w_hp_new;
        end
      end else begin
        // A note change restarts the half period but keeps the output level.
        if (w_new_vld) begin
          r_cnt  <= '0;
          r_note <= w_sel_idx;
          r_hp   <= w_hp_new;
        end else if (w_toggle) begin
          r_cnt   <= '0;
          r_piezo <= ~r_piezo;
          r_hp    <= w_hp_cur;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_next == IDLE) begin
          r_cnt   <= '0;
          r_piezo <= 1'b0;
        end
      end
      if (r_state == RELEASE && !w_new_vld) r_hold <= r_hold + 32'd1;
      else                                  r_hold <= '0;
    end
  end

endmodule
